// File: rtl/mem_stage_pkg.sv
// Shared types, funct3 encodings and lane/alignment helpers for the memory access stage.
package mem_stage_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads; simultaneous read and write is never legal.
    function automatic logic op_legal(input logic [2:0] f3, input logic is_load,
                                      input logic is_store, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = (off[0] == 1'b0);
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load && (off[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok && !(is_load && is_store);
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane selection with sign/zero extension of the returned memory word.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata[8*offset +: 8];
    assign half_s = offset[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane according to the load width and signedness.
    always_comb begin
        value = rdata;
        case (func3)
            F3_B:    value = {{24{byte_s[7]}}, byte_s};
            F3_H:    value = {{16{half_s[15]}}, half_s};
            F3_W:    value = rdata;
            F3_BU:   value = {24'h000000, byte_s};
            F3_HU:   value = {16'h0000, half_s};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: req/ack data-memory port, lane steering, registered writeback.
// Optional BUSY watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 10,
    parameter int RegAddrWidth  = 5,
    parameter int TimeoutCycles = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2:0]              func3,
    input  logic                    reg_en,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic                    mem_to_reg,
    input  logic [RegAddrWidth-1:0] wb_reg,
    input  logic [DataWidth-1:0]    alu_result,
    input  logic [AddrWidth-1:0]    mem_addr,
    input  logic [DataWidth-1:0]    store_data,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [AddrWidth-3:0]    dmem_addr,
    output logic [3:0]              dmem_be,
    output logic [DataWidth-1:0]    dmem_wdata,
    input  logic [DataWidth-1:0]    dmem_rdata,
    input  logic                    dmem_ack,
    output logic                    stall,
    output logic                    wb_en,
    output logic [RegAddrWidth-1:0] wb_addr,
    output logic [DataWidth-1:0]    wb_data,
    output logic                    access_fault
);

    state_t                  state_r, state_next_s;
    logic                    is_mem_s, fault_s, start_s, timeout_s;
    logic [DataWidth-1:0]    wdata_s, load_val_s;
    logic [2:0]              cap_func3_r;
    logic [1:0]              cap_off_r;
    logic                    cap_read_r, cap_wb_en_r;
    logic [RegAddrWidth-1:0] cap_wb_reg_r;

    assign is_mem_s = mem_read | mem_write;
    assign fault_s  = is_mem_s && !op_legal(func3, mem_read, mem_write, mem_addr[1:0]);
    assign start_s  = is_mem_s && !fault_s;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (cap_off_r),
        .func3  (cap_func3_r),
        .value  (load_val_s)
    );

    // Replicate the store lane across the word; byte enables pick the target bytes.
    always_comb begin
        wdata_s = store_data;
        case (func3[1:0])
            2'b00:   wdata_s = {4{store_data[7:0]}};
            2'b01:   wdata_s = {2{store_data[15:0]}};
            default: wdata_s = store_data;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] tmo_cnt_r;

    // Watchdog counts BUSY cycles and is cleared whenever the stage is idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r == BUSY) begin
            tmo_cnt_r <= tmo_cnt_r + {{(CntW-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == BUSY) && !dmem_ack &&
                       (tmo_cnt_r == CntW'(TimeoutCycles - 1));
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TimeoutCycles > 0);
    assign timeout_s        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and upstream stall; stall must be combinational so the op is held on entry.
    always_comb begin
        state_next_s = state_r;
        stall        = 1'b0;
        case (state_r)
            IDLE: begin
                stall        = start_s;
                state_next_s = start_s ? BUSY : IDLE;
            end
            BUSY: begin
                stall        = !dmem_ack;
                state_next_s = (dmem_ack || timeout_s) ? IDLE : BUSY;
            end
            default: begin
                stall        = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // Memory port, captured op and writeback registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'b0000;
            dmem_wdata   <= '0;
            wb_en        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            access_fault <= 1'b0;
            cap_func3_r  <= 3'b000;
            cap_off_r    <= 2'b00;
            cap_read_r   <= 1'b0;
            cap_wb_en_r  <= 1'b0;
            cap_wb_reg_r <= '0;
        end else begin
            access_fault <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fault_s) begin
                        access_fault <= 1'b1;
                        wb_en        <= 1'b0;
                    end else if (start_s) begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= mem_write;
                        dmem_addr    <= mem_addr[AddrWidth-1:2];
                        dmem_be      <= byte_enable(func3, mem_addr[1:0]);
                        dmem_wdata   <= wdata_s;
                        wb_en        <= 1'b0;
                        cap_func3_r  <= func3;
                        cap_off_r    <= mem_addr[1:0];
                        cap_read_r   <= mem_read;
                        cap_wb_en_r  <= reg_en & mem_to_reg;
                        cap_wb_reg_r <= wb_reg;
                    end else begin
                        wb_en   <= reg_en;
                        wb_addr <= wb_reg;
                        wb_data <= alu_result;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (cap_read_r) begin
                            wb_en   <= cap_wb_en_r;
                            wb_addr <= cap_wb_reg_r;
                            wb_data <= load_val_s;
                        end else begin
                            wb_en <= 1'b0;
                        end
                    end else if (timeout_s) begin
                        dmem_req     <= 1'b0;
                        access_fault <= 1'b1;
                        wb_en        <= 1'b0;
                    end else begin
                        wb_en <= 1'b0;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (timeout case only with MEM_TIMEOUT_EN).
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  func3;
    logic        reg_en, mem_read, mem_write, mem_to_reg;
    logic [4:0]  wb_reg;
    logic [31:0] alu_result;
    logic [9:0]  mem_addr;
    logic [31:0] store_data;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        access_fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic        obs_req, obs_we;
    logic [7:0]  obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    int          stalls;

    always #5 clock = ~clock;

    mem_access_stage dut (
        .clock        (clock),
        .reset        (reset),
        .func3        (func3),
        .reg_en       (reg_en),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .wb_reg       (wb_reg),
        .alu_result   (alu_result),
        .mem_addr     (mem_addr),
        .store_data   (store_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall        (stall),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .access_fault (access_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        func3 = 3'b000; reg_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_to_reg = 1'b0; wb_reg = 5'd0; alu_result = 32'h0; mem_addr = 10'h0;
        store_data = 32'h0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [9:0] addr, input logic [31:0] sd, input logic [4:0] rd_idx);
        mem_read = rd; mem_write = wr; func3 = f3; mem_addr = addr; store_data = sd;
        wb_reg = rd_idx; reg_en = rd; mem_to_reg = rd; alu_result = 32'h0;
        #1;
    endtask

    // Drives one access already presented on the inputs; ack arrives after 'waits' BUSY cycles.
    task automatic run_access(input int waits, input logic [31:0] rdata);
        stalls = 0;
        if (stall) stalls++;
        tick();
        obs_req = dmem_req; obs_we = dmem_we; obs_addr = dmem_addr;
        obs_be = dmem_be; obs_wdata = dmem_wdata;
        for (int i = 0; i < waits; i++) begin
            if (stall) stalls++;
            tick();
        end
        dmem_rdata = rdata;
        dmem_ack   = 1'b1;
        #1;
        if (stall) stalls++;
        tick();
        dmem_ack = 1'b0;
        idle_inputs();
        #1;
    endtask

    initial begin
        reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        idle_inputs();
        tick(); tick();
        reset = 1'b0;
        #1;
        check_eq("rst_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);

        // ALU pass-through
        reg_en = 1'b1; wb_reg = 5'd7; alu_result = 32'h0000_1234;
        #1;
        check_eq("alu_stall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("alu_wb_en", {31'd0, wb_en}, 32'd1);
        check_eq("alu_wb_addr", {27'd0, wb_addr}, 32'd7);
        check_eq("alu_wb_data", wb_data, 32'h0000_1234);
        idle_inputs();
        tick();

        // SB to byte 2 of word 1, two wait cycles
        set_op(1'b0, 1'b1, 3'b000, 10'h006, 32'h0000_00AB, 5'd0);
        run_access(2, 32'h0);
        check_eq("sb_req", {31'd0, obs_req}, 32'd1);
        check_eq("sb_we", {31'd0, obs_we}, 32'd1);
        check_eq("sb_addr", {24'd0, obs_addr}, 32'd1);
        check_eq("sb_be", {28'd0, obs_be}, 32'b0100);
        check_eq("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        check_eq("sb_stalls", stalls, 32'd3);
        check_eq("sb_wb_en", {31'd0, wb_en}, 32'd0);
        check_eq("sb_req_done", {31'd0, dmem_req}, 32'd0);

        // SH upper half, SW
        set_op(1'b0, 1'b1, 3'b001, 10'h00A, 32'h1234_ABCD, 5'd0);
        run_access(0, 32'h0);
        check_eq("sh_be", {28'd0, obs_be}, 32'b1100);
        check_eq("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        check_eq("sh_stalls", stalls, 32'd1);
        set_op(1'b0, 1'b1, 3'b010, 10'h3FC, 32'hCAFE_F00D, 5'd0);
        run_access(1, 32'h0);
        check_eq("sw_be", {28'd0, obs_be}, 32'b1111);
        check_eq("sw_addr", {24'd0, obs_addr}, 32'hFF);
        check_eq("sw_wdata", obs_wdata, 32'hCAFE_F00D);

        // Loads with extension
        set_op(1'b1, 1'b0, 3'b000, 10'h003, 32'h0, 5'd5);
        run_access(0, 32'h80FF_0000);
        check_eq("lb_we", {31'd0, obs_we}, 32'd0);
        check_eq("lb_be", {28'd0, obs_be}, 32'b1000);
        check_eq("lb_wb_en", {31'd0, wb_en}, 32'd1);
        check_eq("lb_wb_addr", {27'd0, wb_addr}, 32'd5);
        check_eq("lb_wb_data", wb_data, 32'hFFFF_FF80);
        set_op(1'b1, 1'b0, 3'b100, 10'h003, 32'h0, 5'd6);
        run_access(1, 32'h80FF_0000);
        check_eq("lbu_wb_data", wb_data, 32'h0000_0080);
        set_op(1'b1, 1'b0, 3'b001, 10'h002, 32'h0, 5'd8);
        run_access(0, 32'h80FF_0000);
        check_eq("lh_wb_data", wb_data, 32'hFFFF_80FF);
        set_op(1'b1, 1'b0, 3'b101, 10'h002, 32'h0, 5'd9);
        run_access(0, 32'h80FF_0000);
        check_eq("lhu_wb_data", wb_data, 32'h0000_80FF);
        set_op(1'b1, 1'b0, 3'b010, 10'h010, 32'h0, 5'd10);
        run_access(3, 32'hDEAD_BEEF);
        check_eq("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        check_eq("lw_wb_addr", {27'd0, wb_addr}, 32'd10);
        check_eq("lw_stalls", stalls, 32'd4);

        // Faults: misaligned LW, unsigned store, read+write
        set_op(1'b1, 1'b0, 3'b010, 10'h002, 32'h0, 5'd3);
        check_eq("mis_stall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("mis_fault", {31'd0, access_fault}, 32'd1);
        check_eq("mis_req", {31'd0, dmem_req}, 32'd0);
        check_eq("mis_wb_en", {31'd0, wb_en}, 32'd0);
        idle_inputs();
        tick();
        check_eq("mis_fault_pulse", {31'd0, access_fault}, 32'd0);
        check_eq("mis_req_after", {31'd0, dmem_req}, 32'd0);
        set_op(1'b0, 1'b1, 3'b100, 10'h000, 32'h0, 5'd0);
        check_eq("sbu_stall", {31'd0, stall}, 32'd0);
        tick();
        check_eq("sbu_fault", {31'd0, access_fault}, 32'd1);
        set_op(1'b1, 1'b1, 3'b000, 10'h000, 32'h0, 5'd0);
        tick();
        check_eq("rw_fault", {31'd0, access_fault}, 32'd1);
        check_eq("rw_req", {31'd0, dmem_req}, 32'd0);
        idle_inputs();
        tick();

        // Ack while idle is ignored
        alu_result = 32'h55; dmem_rdata = 32'hFFFF_FFFF; dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check_eq("idle_ack_req", {31'd0, dmem_req}, 32'd0);
        check_eq("idle_ack_wb_data", wb_data, 32'h55);
        idle_inputs();

        // Reset during BUSY abandons the access
        set_op(1'b1, 1'b0, 3'b010, 10'h020, 32'h0, 5'd4);
        tick();
        check_eq("rb_busy_req", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        check_eq("rb_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rb_stall", {31'd0, stall}, 32'd0);
        check_eq("rb_wb_en", {31'd0, wb_en}, 32'd0);
        dmem_rdata = 32'h1111_1111; dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check_eq("rb_late_ack_wb_en", {31'd0, wb_en}, 32'd0);
        check_eq("rb_late_ack_req", {31'd0, dmem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // No ack: watchdog fires after 16 BUSY cycles
        set_op(1'b1, 1'b0, 3'b010, 10'h040, 32'h0, 5'd2);
        tick();
        idle_inputs();
        for (int i = 0; i < 15; i++) tick();
        check_eq("tmo_req_held", {31'd0, dmem_req}, 32'd1);
        check_eq("tmo_no_early_fault", {31'd0, access_fault}, 32'd0);
        check_eq("tmo_stall_held", {31'd0, stall}, 32'd1);
        tick();
        check_eq("tmo_fault", {31'd0, access_fault}, 32'd1);
        check_eq("tmo_req", {31'd0, dmem_req}, 32'd0);
        check_eq("tmo_stall", {31'd0, stall}, 32'd0);
        check_eq("tmo_wb_en", {31'd0, wb_en}, 32'd0);
        tick();
        check_eq("tmo_fault_pulse", {31'd0, access_fault}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
